// File: rtl/sram_like_data_slave.sv
// SRAM-like data-bus responder backed by a word-organised RAM with byte-lane writes.
// Requests are accepted after a programmable hold time; responses return in order after a fixed latency.
module sram_like_data_slave #(
    parameter int ADDR_WIDTH      = 12,
    parameter int ADDR_LATENCY    = 0,
    parameter int DATA_LATENCY    = 1,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_req_i,
    input  logic        data_wr_i,
    input  logic [1:0]  data_size_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_addr_ok_o,
    output logic        data_data_ok_o,
    output logic [31:0] data_rdata_o
);

    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int CD_W   = (DATA_LATENCY > 1) ? $clog2(DATA_LATENCY) : 1;
    localparam int WAIT_W = (ADDR_LATENCY > 0) ? $clog2(ADDR_LATENCY + 1) : 1;

    localparam logic [CD_W-1:0]   CD_INIT  = CD_W'(DATA_LATENCY - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(ADDR_LATENCY);
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(MAX_OUTSTANDING);

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            2'b00:   be = 4'b0001 << a;
            2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == PTR_LAST) begin
            n = '0;
        end else begin
            n = p + PTR_W'(1);
        end
        return n;
    endfunction

    logic [31:0]           mem_q [DEPTH];
    logic [31:0]           ent_rdata_q [MAX_OUTSTANDING];
    logic                  ent_wr_q [MAX_OUTSTANDING];
    logic [CD_W-1:0]       ent_cd_q [MAX_OUTSTANDING];
    logic [MAX_OUTSTANDING-1:0] ent_vld_q;

    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;

    logic [ADDR_WIDTH-1:0] word_idx_s;
    logic [3:0]            be_s;
    logic                  full_s;
    logic                  lat_met_s;
    logic                  data_ok_s;
    logic                  addr_ok_s;
    logic                  unused_addr_s;

    assign word_idx_s    = data_addr_i[ADDR_WIDTH+1:2];
    assign unused_addr_s = &{1'b0, data_addr_i[31:ADDR_WIDTH+2]};
    assign be_s          = byte_en(data_size_i, data_addr_i[1:0]);
    assign full_s        = (count_q == CNT_FULL);

    generate
        if (ADDR_LATENCY == 0) begin : g_no_wait
            assign lat_met_s = 1'b1;
        end else begin : g_wait
            assign lat_met_s = (wait_q >= WAIT_MAX);
        end
    endgenerate

    // A retiring head frees its slot in the same cycle, so a full queue can still accept.
    assign data_ok_s = !rst_i && ent_vld_q[head_q] && (ent_cd_q[head_q] == '0);
    assign addr_ok_s = !rst_i && data_req_i && lat_met_s && (!full_s || data_ok_s);

    // Next-state for queue pointers, occupancy and the address-hold counter.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        wait_d  = wait_q;
        if (data_ok_s) begin
            head_d = ptr_inc(head_q);
        end else begin
            head_d = head_q;
        end
        if (addr_ok_s) begin
            tail_d = ptr_inc(tail_q);
        end else begin
            tail_d = tail_q;
        end
        case ({addr_ok_s, data_ok_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (!data_req_i || addr_ok_s) begin
            wait_d = '0;
        end else if (wait_q != WAIT_MAX) begin
            wait_d = wait_q + WAIT_W'(1);
        end else begin
            wait_d = wait_q;
        end
    end

    // Control state registers with synchronous reset; pending responses are discarded.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            wait_q    <= '0;
            ent_vld_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            wait_q  <= wait_d;
            if (data_ok_s) begin
                ent_vld_q[head_q] <= 1'b0;
            end
            if (addr_ok_s) begin
                ent_vld_q[tail_q] <= 1'b1;
            end
        end
    end

    // Entry payloads; a load captures the pre-write RAM word at the accept edge.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (ent_cd_q[i] != '0) begin
                ent_cd_q[i] <= ent_cd_q[i] - CD_W'(1);
            end
        end
        if (addr_ok_s) begin
            ent_cd_q[tail_q]    <= CD_INIT;
            ent_wr_q[tail_q]    <= data_wr_i;
            ent_rdata_q[tail_q] <= data_wr_i ? 32'h0000_0000 : mem_q[word_idx_s];
        end
    end

    // RAM store port; contents are intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (addr_ok_s && data_wr_i) begin
            for (int k = 0; k < 4; k++) begin
                if (be_s[k]) begin
                    mem_q[word_idx_s][8*k +: 8] <= data_wdata_i[8*k +: 8];
                end
            end
        end
    end

    always_comb begin
        data_addr_ok_o = addr_ok_s;
        data_data_ok_o = data_ok_s;
        if (data_ok_s && !ent_wr_q[head_q]) begin
            data_rdata_o = ent_rdata_q[head_q];
        end else begin
            data_rdata_o = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_sram_like_data_slave.sv
// Directed bench: three responders (default, long data latency, address hold) on one clock.
module tb_sram_like_data_slave;

    logic clk;
    logic rst;
    int   total;
    int   passed;

    logic        a_req, a_wr, a_aok, a_dok;
    logic [1:0]  a_size;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        b_req, b_wr, b_aok, b_dok;
    logic [1:0]  b_size;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic        c_req, c_wr, c_aok, c_dok;
    logic [1:0]  c_size;
    logic [31:0] c_addr, c_wdata, c_rdata;

    sram_like_data_slave #(.ADDR_WIDTH(8)) u_a (
        .clk_i(clk), .rst_i(rst), .data_req_i(a_req), .data_wr_i(a_wr),
        .data_size_i(a_size), .data_addr_i(a_addr), .data_wdata_i(a_wdata),
        .data_addr_ok_o(a_aok), .data_data_ok_o(a_dok), .data_rdata_o(a_rdata));

    sram_like_data_slave #(.ADDR_WIDTH(8), .DATA_LATENCY(3), .MAX_OUTSTANDING(2)) u_b (
        .clk_i(clk), .rst_i(rst), .data_req_i(b_req), .data_wr_i(b_wr),
        .data_size_i(b_size), .data_addr_i(b_addr), .data_wdata_i(b_wdata),
        .data_addr_ok_o(b_aok), .data_data_ok_o(b_dok), .data_rdata_o(b_rdata));

    sram_like_data_slave #(.ADDR_WIDTH(8), .ADDR_LATENCY(2)) u_c (
        .clk_i(clk), .rst_i(rst), .data_req_i(c_req), .data_wr_i(c_wr),
        .data_size_i(c_size), .data_addr_i(c_addr), .data_wdata_i(c_wdata),
        .data_addr_ok_o(c_aok), .data_data_ok_o(c_dok), .data_rdata_o(c_rdata));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic a_drive(input logic req, input logic wr, input logic [1:0] sz,
                           input logic [31:0] ad, input logic [31:0] wd);
        a_req = req; a_wr = wr; a_size = sz; a_addr = ad; a_wdata = wd;
    endtask

    task automatic b_drive(input logic req, input logic wr, input logic [31:0] ad,
                           input logic [31:0] wd);
        b_req = req; b_wr = wr; b_size = 2'b10; b_addr = ad; b_wdata = wd;
    endtask

    task automatic c_drive(input logic req, input logic wr, input logic [31:0] ad,
                           input logic [31:0] wd);
        c_req = req; c_wr = wr; c_size = 2'b10; c_addr = ad; c_wdata = wd;
    endtask

    // Single store on the long-latency instance, then idle until its response retires.
    task automatic b_store(input logic [31:0] ad, input logic [31:0] wd);
        b_drive(1'b1, 1'b1, ad, wd);
        #1;
        chk("b_init_aok", {31'd0, b_aok}, 32'd1);
        cyc();
        b_drive(1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) cyc();
    endtask

    initial begin
        total = 0;
        passed = 0;
        rst = 1'b1;
        a_drive(1'b1, 1'b0, 2'b10, 32'h100, 32'h0);
        b_drive(1'b1, 1'b0, 32'h10, 32'h0);
        c_drive(1'b1, 1'b0, 32'h20, 32'h0);
        repeat (2) cyc();
        #1;
        chk("rst_a_aok", {31'd0, a_aok}, 32'd0);
        chk("rst_a_dok", {31'd0, a_dok}, 32'd0);
        chk("rst_a_rdata", a_rdata, 32'h0);
        chk("rst_b_aok", {31'd0, b_aok}, 32'd0);
        chk("rst_c_aok", {31'd0, c_aok}, 32'd0);

        // ---- default instance: store then load ----
        cyc();
        rst = 1'b0;
        b_drive(1'b0, 1'b0, 32'h0, 32'h0);
        c_drive(1'b0, 1'b0, 32'h0, 32'h0);
        a_drive(1'b1, 1'b1, 2'b10, 32'h100, 32'h1122_3344);
        #1;
        chk("sw_aok", {31'd0, a_aok}, 32'd1);
        chk("sw_dok_early", {31'd0, a_dok}, 32'd0);
        cyc();
        a_drive(1'b1, 1'b0, 2'b10, 32'h100, 32'h0);
        #1;
        chk("sw_dok", {31'd0, a_dok}, 32'd1);
        chk("sw_rdata", a_rdata, 32'h0);
        chk("lw_aok", {31'd0, a_aok}, 32'd1);
        cyc();
        a_drive(1'b0, 1'b0, 2'b10, 32'h0, 32'h0);
        #1;
        chk("lw_dok", {31'd0, a_dok}, 32'd1);
        chk("lw_rdata", a_rdata, 32'h1122_3344);
        cyc();
        #1;
        chk("lw_dok_one_wide", {31'd0, a_dok}, 32'd0);
        chk("idle_rdata", a_rdata, 32'h0);

        // ---- byte enables: SB, SH, LW, byte-size read, aliased read ----
        a_drive(1'b1, 1'b1, 2'b00, 32'h101, 32'hA5A5_A5A5);
        #1;
        chk("sb_aok", {31'd0, a_aok}, 32'd1);
        cyc();
        a_drive(1'b1, 1'b1, 2'b01, 32'h102, 32'hBEEF_BEEF);
        cyc();
        a_drive(1'b1, 1'b0, 2'b10, 32'h100, 32'h0);
        cyc();
        a_drive(1'b1, 1'b0, 2'b00, 32'h103, 32'h0);
        #1;
        chk("be_lw_rdata", a_rdata, 32'hBEEF_A544);
        cyc();
        a_drive(1'b1, 1'b0, 2'b10, 32'h8000_0100, 32'h0);
        #1;
        chk("be_lb_rdata", a_rdata, 32'hBEEF_A544);
        cyc();
        a_drive(1'b0, 1'b0, 2'b10, 32'h0, 32'h0);
        #1;
        chk("alias_rdata", a_rdata, 32'hBEEF_A544);
        cyc();

        // ---- long latency: three back-to-back loads with queue depth 2 ----
        b_store(32'h10, 32'hAAAA_0001);
        b_store(32'h14, 32'hBBBB_0002);
        b_store(32'h18, 32'hCCCC_0003);
        b_drive(1'b1, 1'b0, 32'h10, 32'h0);
        #1;
        chk("q_ld0_aok", {31'd0, b_aok}, 32'd1);
        cyc();
        b_drive(1'b1, 1'b0, 32'h14, 32'h0);
        #1;
        chk("q_ld1_aok", {31'd0, b_aok}, 32'd1);
        cyc();
        b_drive(1'b1, 1'b0, 32'h18, 32'h0);
        #1;
        chk("q_full_aok", {31'd0, b_aok}, 32'd0);
        chk("q_full_dok", {31'd0, b_dok}, 32'd0);
        cyc();
        #1;
        chk("q_pop0_dok", {31'd0, b_dok}, 32'd1);
        chk("q_pop0_rdata", b_rdata, 32'hAAAA_0001);
        chk("q_pop_push_aok", {31'd0, b_aok}, 32'd1);
        cyc();
        b_drive(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("q_pop1_rdata", b_rdata, 32'hBBBB_0002);
        cyc();
        #1;
        chk("q_gap_dok", {31'd0, b_dok}, 32'd0);
        cyc();
        #1;
        chk("q_pop2_dok", {31'd0, b_dok}, 32'd1);
        chk("q_pop2_rdata", b_rdata, 32'hCCCC_0003);
        cyc();

        // ---- read-before-write ordering ----
        b_drive(1'b1, 1'b0, 32'h10, 32'h0);
        cyc();
        b_drive(1'b1, 1'b1, 32'h10, 32'h5555_AAAA);
        #1;
        chk("rbw_sw_aok", {31'd0, b_aok}, 32'd1);
        cyc();
        b_drive(1'b0, 1'b0, 32'h0, 32'h0);
        cyc();
        #1;
        chk("rbw_old_rdata", b_rdata, 32'hAAAA_0001);
        cyc();
        #1;
        chk("rbw_sw_dok", {31'd0, b_dok}, 32'd1);
        chk("rbw_sw_rdata", b_rdata, 32'h0);
        b_drive(1'b1, 1'b0, 32'h10, 32'h0);
        cyc();
        b_drive(1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) cyc();
        #1;
        chk("rbw_new_rdata", b_rdata, 32'h5555_AAAA);
        cyc();

        // ---- reset drops pending responses ----
        b_drive(1'b1, 1'b0, 32'h10, 32'h0);
        cyc();
        b_drive(1'b1, 1'b0, 32'h14, 32'h0);
        cyc();
        b_drive(1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rst_drop_dok", {31'd0, b_dok}, 32'd0);
            cyc();
        end
        a_drive(1'b1, 1'b1, 2'b10, 32'h100, 32'h1122_3344);
        #1;
        chk("post_rst_sw_aok", {31'd0, a_aok}, 32'd1);
        cyc();
        a_drive(1'b1, 1'b0, 2'b10, 32'h100, 32'h0);
        #1;
        chk("post_rst_sw_dok", {31'd0, a_dok}, 32'd1);
        cyc();
        a_drive(1'b0, 1'b0, 2'b10, 32'h0, 32'h0);
        #1;
        chk("post_rst_lw_rdata", a_rdata, 32'h1122_3344);
        cyc();

        // ---- address hold of two cycles ----
        c_drive(1'b1, 1'b1, 32'h20, 32'h1234_5678);
        #1;
        chk("al_c0_aok", {31'd0, c_aok}, 32'd0);
        cyc();
        #1;
        chk("al_c1_aok", {31'd0, c_aok}, 32'd0);
        cyc();
        #1;
        chk("al_c2_aok", {31'd0, c_aok}, 32'd1);
        cyc();
        c_drive(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("al_sw_dok", {31'd0, c_dok}, 32'd1);
        c_drive(1'b1, 1'b0, 32'h20, 32'h0);
        cyc();
        c_drive(1'b0, 1'b0, 32'h20, 32'h0);
        cyc();
        c_drive(1'b1, 1'b0, 32'h20, 32'h0);
        #1;
        chk("al_restart0_aok", {31'd0, c_aok}, 32'd0);
        cyc();
        #1;
        chk("al_restart1_aok", {31'd0, c_aok}, 32'd0);
        cyc();
        #1;
        chk("al_restart2_aok", {31'd0, c_aok}, 32'd1);
        cyc();
        c_drive(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("al_lw_rdata", c_rdata, 32'h1234_5678);
        cyc();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
